uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller for one uart_rx. Owns its config inputs (baudrate/stop_bits/parity_*) and its valid gate.
//  Applies host config changes only between frames. Captures each completed byte with its parity status
//  into a receive FIFO, filters false starts, and keeps saturating error counters. Sits between uart_rx and
//  the host/bus side, which reads bytes over a valid/ready stream.
// PARAMETERS
//  CLK_HZ         25000000  clock frequency (Hz); divider numerator
//  DEF_BAUD       115200    baudrate driven after reset
//  FIFO_DEPTH     16        receive FIFO entries; power of 2, >=2
//  CNT_W          16        width of error counters
//  MIN_FRAME_BITS 4         minimum rx_ready-low time, in bit periods, for a frame to be accepted
// PORTS
//  clk            in   1      clock (25 MHz nominal)
//  rst_n          in   1      asynchronous active-low reset
//  enable         in   1      1 = receive enabled
//  cfg_wr         in   1      1-cycle strobe: latch cfg_* into shadow, mark pending
//  cfg_baudrate   in   32     requested baudrate
//  cfg_stop_bits  in   2      0=1, 1=2, 2=1.5 stop bits; 3 illegal
//  cfg_parity_en  in   1      parity enable
//  cfg_parity_type in  1      0=even, 1=odd
//  cfg_err        out  1      1-cycle pulse: cfg_wr rejected
//  cfg_busy       out  1      1 while a config is pending or being applied
//  rx_valid       out  1      -> uart_rx.valid
//  rx_baudrate    out  32     -> uart_rx.baudrate
//  rx_stop_bits   out  2      -> uart_rx.stop_bits
//  rx_parity_en   out  1      -> uart_rx.parity_en
//  rx_parity_type out  1      -> uart_rx.parity_type
//  rx_ready       in   1      <- uart_rx.ready
//  rx_data        in   8      <- uart_rx.rx_data
//  rx_parity_ok   in   1      <- uart_rx.parity_valid
//  out_valid      out  1      FIFO not empty
//  out_data       out  8      head byte
//  out_perr       out  1      head byte had a parity error
//  out_ready      in   1      host pop; pop = out_valid & out_ready
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overrun_cnt    out  CNT_W  bytes dropped because the FIFO was full; saturating
//  perr_cnt       out  CNT_W  bytes stored with parity error; saturating
//  cnt_clr        in   1      synchronous clear of both counters; wins over increment
// BEHAVIOUR
//  Reset values
//   - State DISABLED; rx_valid=0; rx_baudrate=DEF_BAUD; stop/parity outputs 0.
//   - bit_period=CLK_HZ/DEF_BAUD (constant); FIFO empty; counters 0; pending cleared.
//   - cfg_err=0, cfg_busy=0. rdy_d (registered rx_ready) resets to 1.
//  cfg_wr
//   - Rejected (cfg_err pulse next cycle, shadow unchanged) if cfg_baudrate==0,
//     cfg_baudrate>CLK_HZ/2, or cfg_stop_bits==3.
//   - Otherwise latch shadow and set pending. A later cfg_wr overwrites the shadow; last write wins.
//  FSM states
//   - DISABLED: rx_valid=0.
//     -> DIV if pending. -> ARMED if enable.
//   - ARMED: rx_valid=1.
//     -> FRAME on rx_ready falling edge (rdy_d=1, rx_ready=0); clear low_cnt.
//     -> DRAIN if pending & rx_ready=1. -> DISABLED if !enable & rx_ready=1.
//   - DRAIN: rx_valid=0 for exactly 1 cycle.
//     -> if rx_ready==0 (frame began on the gating edge): rx_valid=1, go FRAME; pending kept.
//     -> else DIV.
//   - DIV: copy shadow to rx_* outputs on entry. Run a 32-cycle restoring divide,
//     bit_period = CLK_HZ/baudrate; rx_valid=0; pending cleared on exit.
//     -> ARMED if enable, else DISABLED. Latency cfg_wr->ARMED = 34 cycles when idle.
//   - FRAME: rx_valid=1; low_cnt increments (saturating, 32 bit) while rx_ready=0.
//     On rx_ready rising edge, capture rx_data/rx_parity_ok that same cycle (valid only then).
//     Accept if low_cnt >= MIN_FRAME_BITS*bit_period; else discard silently (false start, data=0).
//     -> ARMED (enable still high) or DISABLED. enable dropping mid-frame lets the frame finish.
//  FIFO
//   - Accepted byte pushed at the capture edge; out_valid high the next cycle.
//   - Full & no pop: byte dropped, overrun_cnt++.
//   - Full & pop same cycle: push accepted, level unchanged.
//   - Empty: out_data holds the last value, out_valid=0.
//   - perr_cnt++ for each stored byte with rx_parity_ok=0; dropped bytes do not count.
//   - Pointers wrap modulo FIFO_DEPTH; level is the extra-bit difference.
//  Counters stick at 2^CNT_W-1. Async reset at any point aborts the frame and empties the FIFO.
// STRUCTURE
//  - uart_pkg: FSM state encoding, stop_bits codes, CFG_STOP_ILLEGAL, MAX_BAUD(CLK_HZ).
//  - Sub-module uart_rx_fifo: synchronous FIFO with WIDTH=9 and DEPTH params, push/pop/full/empty/level.
//  - Divider and FSM stay inline.
// TESTING
//  - Reset, enable=1, send 0xA5 8N1 @115200 -> ARMED; one push; out_data=0xA5, out_perr=0, fifo_level=1.
//  - cfg 9600/odd parity/2 stop; send 0x3C with wrong parity bit -> out_perr=1, perr_cnt=1, cfg_busy low at 34 cycles.
//  - 50-cycle rx glitch low -> uart_rx false start; no push, counters unchanged.
//  - out_ready=0, 17 bytes -> level=16, overrun_cnt=1; then pop+push same cycle -> level stays 16.
//  - cfg_wr mid-frame -> frame completes with old baud, new cfg applied after; cfg_baudrate=0 -> cfg_err, no change.
//  - rst_n low mid-frame -> all outputs at reset values, FIFO empty; cnt_clr with overrun pending -> counter 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, stop-bit codes and config limits for the uart_rx controller
package uart_pkg;
    typedef enum logic [2:0] {S_DISABLED, S_ARMED, S_DRAIN, S_DIV, S_FRAME} state_e;
    typedef enum logic [1:0] {STOP_1, STOP_2, STOP_1P5, STOP_BAD} stop_e;
    localparam logic [1:0] CFG_STOP_ILLEGAL = 2'd3;
    function automatic logic [31:0] MAX_BAUD(input int unsigned clk_hz);
        return 32'(clk_hz / 2);
    endfunction
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO; the head output holds the last popped word while empty
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic [AW:0] wr_q, rd_q;
    logic wr, rd;
    assign level_o = wr_q - rd_q;
    assign empty_o = wr_q == rd_q;
    assign full_o  = level_o[AW];
    assign rd      = pop_i & ~empty_o;
    assign wr      = push_i & (~full_o | rd);
    assign rdata_o = empty_o ? last_q : mem_q[rd_q[AW-1:0]];
    // storage array, no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
    // pointers with an extra wrap bit, plus the word most recently popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
        end else begin
            if (wr) wr_q <= wr_q + 1'b1;
            if (rd) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= rdata_o;
            end
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config gating, frame filtering, receive FIFO and error counters around one uart_rx
module uart_rx_ctrl import uart_pkg::*; #(
    parameter int unsigned CLK_HZ         = 25000000,
    parameter int unsigned DEF_BAUD       = 115200,
    parameter int          FIFO_DEPTH     = 16,
    parameter int          CNT_W          = 16,
    parameter int unsigned MIN_FRAME_BITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cfg_wr,
    input  logic [31:0]                   cfg_baudrate,
    input  logic [1:0]                    cfg_stop_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_type,
    output logic                          cfg_err,
    output logic                          cfg_busy,
    output logic                          rx_valid,
    output logic [31:0]                   rx_baudrate,
    output logic [1:0]                    rx_stop_bits,
    output logic                          rx_parity_en,
    output logic                          rx_parity_type,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_parity_ok,
    output logic                          out_valid,
    output logic [7:0]                    out_data,
    output logic                          out_perr,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              overrun_cnt,
    output logic [CNT_W-1:0]              perr_cnt,
    input  logic                          cnt_clr
);
    state_e state_q;
    logic pending_q, cfg_err_q, rdy_q, rx_valid_q;
    logic [31:0] sh_baud_q, baud_q, bit_period_q, low_cnt_q, quo_q, rem_q;
    logic [1:0] sh_stop_q, stop_q;
    logic sh_pen_q, sh_ptype_q, pen_q, ptype_q;
    logic [4:0] div_cnt_q;
    logic [CNT_W-1:0] overrun_q, perr_q;
    logic [32:0] rem_sh, rem_sub;
    logic [31:0] rem_d, quo_d;
    logic [63:0] thr;
    logic [8:0] head;
    logic cfg_ok, cfg_take, rem_ge, go_div, push, pop, full, empty, stored, drop;
    assign cfg_ok   = cfg_baudrate != 0 && cfg_baudrate <= MAX_BAUD(CLK_HZ) && cfg_stop_bits != CFG_STOP_ILLEGAL;
    assign cfg_take = cfg_wr & cfg_ok;
    // one restoring-division step per cycle: dividend CLK_HZ shifts out of quo_q into rem_q
    assign rem_sh   = {rem_q, quo_q[31]};
    assign rem_sub  = rem_sh - {1'b0, baud_q};
    assign rem_ge   = ~rem_sub[32];
    assign rem_d    = rem_ge ? rem_sub[31:0] : rem_sh[31:0];
    assign quo_d    = {quo_q[30:0], rem_ge};
    assign thr      = 64'(bit_period_q) * 64'(MIN_FRAME_BITS);
    assign go_div   = (state_q == S_DISABLED && pending_q) || (state_q == S_DRAIN && rx_ready);
    assign push     = state_q == S_FRAME && rx_ready && {32'd0, low_cnt_q} >= thr;
    assign pop      = out_valid & out_ready;
    assign stored   = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign out_valid      = ~empty;
    assign out_data       = head[7:0];
    assign out_perr       = head[8];
    assign cfg_err        = cfg_err_q;
    assign cfg_busy       = pending_q | (state_q == S_DIV);
    assign rx_valid       = rx_valid_q;
    assign rx_baudrate    = baud_q;
    assign rx_stop_bits   = stop_q;
    assign rx_parity_en   = pen_q;
    assign rx_parity_type = ptype_q;
    assign overrun_cnt    = overrun_q;
    assign perr_cnt       = perr_q;
    uart_rx_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
        .wdata_i({~rx_parity_ok, rx_data}), .rdata_o(head),
        .full_o(full), .empty_o(empty), .level_o(fifo_level)
    );
    // host config shadow; a rejected write only raises the error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q  <= 1'b0;
            sh_baud_q  <= DEF_BAUD;
            sh_stop_q  <= '0;
            sh_pen_q   <= 1'b0;
            sh_ptype_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_wr & ~cfg_ok;
            if (cfg_take) begin
                sh_baud_q  <= cfg_baudrate;
                sh_stop_q  <= cfg_stop_bits;
                sh_pen_q   <= cfg_parity_en;
                sh_ptype_q <= cfg_parity_type;
            end
        end
    end
    // controller FSM: gates uart_rx, applies config between frames, runs the divider, times frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_DISABLED;
            pending_q    <= 1'b0;
            rdy_q        <= 1'b1;
            rx_valid_q   <= 1'b0;
            baud_q       <= DEF_BAUD;
            stop_q       <= '0;
            pen_q        <= 1'b0;
            ptype_q      <= 1'b0;
            bit_period_q <= 32'(CLK_HZ / DEF_BAUD);
            low_cnt_q    <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            div_cnt_q    <= '0;
        end else begin
            rdy_q <= rx_ready;
            case (state_q)
                S_DISABLED: if (!pending_q && enable) begin
                    state_q    <= S_ARMED;
                    rx_valid_q <= 1'b1;
                end
                S_ARMED: if (rdy_q && !rx_ready) begin
                    state_q   <= S_FRAME;
                    low_cnt_q <= '0;
                end else if (pending_q && rx_ready) begin
                    state_q    <= S_DRAIN;
                    rx_valid_q <= 1'b0;
                end else if (!enable && rx_ready) begin
                    state_q    <= S_DISABLED;
                    rx_valid_q <= 1'b0;
                end
                S_DRAIN: if (!rx_ready) begin
                    state_q    <= S_FRAME;
                    rx_valid_q <= 1'b1;
                    low_cnt_q  <= '0;
                end
                S_DIV: begin
                    rem_q     <= rem_d;
                    quo_q     <= quo_d;
                    div_cnt_q <= div_cnt_q + 1'b1;
                    if (&div_cnt_q) begin
                        bit_period_q <= quo_d;
                        pending_q    <= 1'b0;
                        state_q      <= enable ? S_ARMED : S_DISABLED;
                        rx_valid_q   <= enable;
                    end
                end
                S_FRAME: if (rx_ready) begin
                    state_q    <= enable ? S_ARMED : S_DISABLED;
                    rx_valid_q <= enable;
                end else if (~&low_cnt_q) begin
                    low_cnt_q <= low_cnt_q + 1'b1;
                end
                default: state_q <= S_DISABLED;
            endcase
            if (go_div) begin
                state_q    <= S_DIV;
                rx_valid_q <= 1'b0;
                baud_q     <= sh_baud_q;
                stop_q     <= sh_stop_q;
                pen_q      <= sh_pen_q;
                ptype_q    <= sh_ptype_q;
                quo_q      <= 32'(CLK_HZ);
                rem_q      <= '0;
                div_cnt_q  <= '0;
            end
            if (cfg_take) pending_q <= 1'b1;
        end
    end
    // saturating error counters; clear takes priority over an increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= '0;
            perr_q    <= '0;
        end else if (cnt_clr) begin
            overrun_q <= '0;
            perr_q    <= '0;
        end else begin
            if (drop && ~&overrun_q) overrun_q <= overrun_q + 1'b1;
            if (stored && !rx_parity_ok && ~&perr_q) perr_q <= perr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed checks of config gating, frame filtering, FIFO and counters
module tb_uart_rx_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_wr = 1'b0;
    logic [31:0] cfg_baudrate = 32'd0;
    logic [1:0] cfg_stop_bits = 2'd0;
    logic cfg_parity_en = 1'b0, cfg_parity_type = 1'b0;
    logic cfg_err, cfg_busy, rx_valid, rx_parity_en, rx_parity_type;
    logic [31:0] rx_baudrate;
    logic [1:0] rx_stop_bits;
    logic rx_ready = 1'b1, rx_parity_ok = 1'b1, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [7:0] rx_data = 8'd0, out_data;
    logic out_valid, out_perr;
    logic [4:0] fifo_level;
    logic [15:0] overrun_cnt, perr_cnt;
    int n_checks = 0, n_pass = 0;

    always #20 clk = ~clk;

    uart_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_wr(cfg_wr),
        .cfg_baudrate(cfg_baudrate), .cfg_stop_bits(cfg_stop_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
        .cfg_err(cfg_err), .cfg_busy(cfg_busy), .rx_valid(rx_valid),
        .rx_baudrate(rx_baudrate), .rx_stop_bits(rx_stop_bits),
        .rx_parity_en(rx_parity_en), .rx_parity_type(rx_parity_type),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_parity_ok(rx_parity_ok),
        .out_valid(out_valid), .out_data(out_data), .out_perr(out_perr),
        .out_ready(out_ready), .fifo_level(fifo_level),
        .overrun_cnt(overrun_cnt), .perr_cnt(perr_cnt), .cnt_clr(cnt_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] baud, input logic [1:0] stop, input logic pen, input logic ptype);
        cfg_baudrate = baud; cfg_stop_bits = stop; cfg_parity_en = pen; cfg_parity_type = ptype;
        cfg_wr = 1'b1;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    // uart_rx stand-in: ready low for `low` cycles, then high with the byte on the rising edge
    task automatic send(input logic [7:0] d, input logic pok, input int low);
        rx_data = d; rx_parity_ok = pok; rx_ready = 1'b0;
        tick(low);
        rx_ready = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(3);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_baud", rx_baudrate, 115200);
        check("rst_level", fifo_level, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", cfg_busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ovr", overrun_cnt, 0);
        rst_n = 1'b1; enable = 1'b1;
        tick(1);
        check("armed_valid", rx_valid, 1);
        // 0xA5 at 115200: threshold 4*217=868 cycles low
        send(8'hA5, 1'b1, 888);
        check("a5_valid", out_valid, 1);
        check("a5_data", out_data, 8'hA5);
        check("a5_perr", out_perr, 0);
        check("a5_level", fifo_level, 1);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        check("a5_pop_empty", out_valid, 0);
        check("a5_hold", out_data, 8'hA5);
        tick(2);
        // 9600, 2 stop, odd parity; busy drops exactly 34 cycles after cfg_wr
        cfg(32'd9600, 2'd1, 1'b1, 1'b1);
        tick(33);
        check("div_busy33", cfg_busy, 1);
        check("div_valid33", rx_valid, 0);
        tick(1);
        check("div_busy34", cfg_busy, 0);
        check("div_valid34", rx_valid, 1);
        check("div_baud", rx_baudrate, 9600);
        check("div_stop", rx_stop_bits, 1);
        check("div_pen", rx_parity_en, 1);
        check("div_ptype", rx_parity_type, 1);
        // new threshold 4*2604=10416: 10399 counted is short, 10435 is enough
        send(8'h11, 1'b1, 10400);
        check("short9600_level", fifo_level, 0);
        tick(2);
        send(8'h3C, 1'b0, 10436);
        check("3c_data", out_data, 8'h3C);
        check("3c_perr", out_perr, 1);
        check("3c_perr_cnt", perr_cnt, 1);
        out_ready = 1'b1; tick(1); out_ready = 1'b0;
        tick(2);
        send(8'h77, 1'b0, 50);
        check("glitch_level", fifo_level, 0);
        check("glitch_perr", perr_cnt, 1);
        check("glitch_ovr", overrun_cnt, 0);
        tick(2);
        // back to 115200, then fill past full with the host stalled
        cfg(32'd115200, 2'd0, 1'b0, 1'b0);
        tick(36);
        for (int i = 0; i < 17; i++) begin
            send(8'h40 + 8'(i), 1'b1, 888);
            tick(2);
        end
        check("full_level", fifo_level, 16);
        check("full_ovr", overrun_cnt, 1);
        check("full_head", out_data, 8'h40);
        check("full_perr", perr_cnt, 1);
        rx_data = 8'h99; rx_ready = 1'b0;
        tick(888);
        rx_ready = 1'b1; out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("poppush_level", fifo_level, 16);
        check("poppush_ovr", overrun_cnt, 1);
        check("poppush_head", out_data, 8'h41);
        out_ready = 1'b1; tick(16); out_ready = 1'b0;
        check("drain_level", fifo_level, 0);
        check("drain_last", out_data, 8'h99);
        tick(2);
        // cfg_wr mid-frame: frame still judged with the 115200 period
        rx_data = 8'h5A; rx_parity_ok = 1'b1; rx_ready = 1'b0;
        tick(10);
        cfg(32'd9600, 2'd2, 1'b0, 1'b0);
        check("mid_busy", cfg_busy, 1);
        check("mid_baud_old", rx_baudrate, 115200);
        check("mid_valid", rx_valid, 1);
        tick(877);
        rx_ready = 1'b1;
        tick(1);
        check("mid_level", fifo_level, 1);
        check("mid_data", out_data, 8'h5A);
        tick(34);
        check("mid_busy_done", cfg_busy, 0);
        check("mid_baud_new", rx_baudrate, 9600);
        check("mid_stop_new", rx_stop_bits, 2);
        cfg(32'd0, 2'd0, 1'b0, 1'b0);
        check("baud0_err", cfg_err, 1);
        check("baud0_busy", cfg_busy, 0);
        tick(1);
        check("baud0_err_pulse", cfg_err, 0);
        check("baud0_nochange", rx_baudrate, 9600);
        cfg(32'd115200, 2'd3, 1'b0, 1'b0);
        check("stop3_err", cfg_err, 1);
        cfg(32'd12500001, 2'd0, 1'b0, 1'b0);
        check("fast_err", cfg_err, 1);
        tick(1);
        check("rej_busy", cfg_busy, 0);
        // async reset in the middle of a frame
        rx_ready = 1'b0;
        tick(100);
        rst_n = 1'b0;
        #1;
        check("arst_valid", rx_valid, 0);
        check("arst_level", fifo_level, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_baud", rx_baudrate, 115200);
        check("arst_stop", rx_stop_bits, 0);
        check("arst_ovr", overrun_cnt, 0);
        check("arst_perr", perr_cnt, 0);
        rx_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 17; i++) begin
            send(8'h80 + 8'(i), 1'b1, 888);
            tick(2);
        end
        check("clr_pre_ovr", overrun_cnt, 1);
        rx_data = 8'hEE; rx_ready = 1'b0;
        tick(888);
        rx_ready = 1'b1; cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("clr_ovr", overrun_cnt, 0);
        check("clr_level", fifo_level, 16);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
